imem_dmem_arbiter: RTL
======================

# imem_dmem_arbiter

Single-port memory arbiter for the rv32i pipeline. It shares one instruction/data memory port between the fetch path (PC to instruction) and the load/store path of the memory stage. It runs one memory transaction at a time through a request/grant/response FSM. It also drives the fetch stall that holds `PCF`/decode while fetch is waiting.

## Interface
Parameters:
- `DPW`, 32 (from `rv32i_pkg`): data/instruction width.
- `ADW`, 32 (from `rv32i_pkg`): address width.
- `MaxDataWins`, 4: consecutive data wins allowed while fetch is pending before fetch is forced to win (1–15).
- `TimeoutCycles`, 64: maximum cycles allowed in WAIT_RSP (used only with the timeout feature; 2–255).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in ADW: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out DPW: instruction.
- `stall_fetch` out 1: `if_req` high and fetch response not yet returned.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: byte enables.
- `d_addr` in ADW: data address.
- `d_wdata` in DPW: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: load data valid, or store complete.
- `d_rdata` out DPW: load data.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out ADW: memory address.
- `mem_wdata` out DPW: memory write data.
- `mem_gnt` in 1: memory accepted `mem_req`.
- `mem_rvalid` in 1: memory response valid.
- `mem_rdata` in DPW: memory response data.
- `err` out 1: timeout pulse (tied 0 when timeout is compiled out).

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_RSP.
- **IDLE:**
  - If any request is present, pick a winner and assert that requester's `gnt` (combinational, same cycle).
  - Latch command (addr, we, be, wdata; fetch uses we=0, be=4'hF) and `owner` into registers; go to ISSUE.
- **Arbitration:**
  - Data wins by default.
  - If `if_req` is pending and `data_wins` == `MaxDataWins`, fetch wins.
  - `data_wins` increments when data wins while `if_req` is high.
  - `data_wins` clears when fetch wins or `if_req` is low; it saturates at `MaxDataWins`.
- **ISSUE:**
  - `mem_req`=1 with the latched command, held stable until `mem_gnt`.
  - On `mem_gnt`, go to WAIT_RSP.
- **WAIT_RSP:**
  - On `mem_rvalid`, pass `mem_rdata` to the owner's `rdata` and assert the owner's `rvalid` (combinational, same cycle); go to IDLE.
  - Store responses assert `d_rvalid`; `d_rdata` is don't-care.
- **Ignored response:** `mem_rvalid` outside WAIT_RSP is ignored.
- **stall_fetch:** `if_req & ~(if_rvalid)`.
- **rdata outputs:** 0 when the matching `rvalid` is low.
- **Reset:**
  - state=IDLE, `data_wins`=0, timeout counter=0, owner=data.
  - All outputs 0 except `stall_fetch`, which follows `if_req`.
  - Reset mid-transaction abandons it; a late `mem_rvalid` arriving in IDLE is dropped.

## Timing
- **Minimum round trip:**
  - Cycle N: req high, gnt.
  - Cycle N+1: `mem_req` with `mem_gnt`=1.
  - Cycle N+2: `mem_rvalid`, requester `rvalid`.
  - Cycle N+3: next grant possible.
- **Outstanding transactions:** exactly one; no new grant is possible before returning to IDLE.
- **Simultaneous `if_req` and `d_req` in IDLE:** exactly one `gnt`, per the arbitration rule.
- **Single grant:** `if_gnt` and `d_gnt` are never both high.
- **Held requests:** a request dropped before its `gnt` is a protocol error; behaviour is undefined.
- **Per-cycle limit:** at most one `gnt` and at most one `rvalid` per cycle.

## Configuration
- **Macro:** `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter runs in WAIT_RSP.
  - When it reaches `TimeoutCycles` without `mem_rvalid`: pulse `err` for 1 cycle, assert owner `rvalid` with `rdata`=0 that same cycle, go to IDLE.
  - The counter clears on entry to WAIT_RSP.
- **Undefined:**
  - No counter; WAIT_RSP waits indefinitely.
  - `err` is constant 0.

## Test plan
- **Reset:** `rst`=1 with `if_req`=1 mid WAIT_RSP; drive `mem_rvalid` the cycle after reset releases -> state IDLE, `if_rvalid`=0, late response dropped, next `if_req` granted.
- **Single fetch:** `if_req`, `if_addr`=0x100; memory grants immediately and returns 0x00500093 one cycle later -> `if_gnt` at N, `mem_addr`=0x100 and `mem_we`=0 at N+1, `if_rvalid` with `if_rdata`=0x00500093 at N+2.
- **Simultaneous requests:** `if_req` and `d_req` (store, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_be`=4'hF) together -> `d_gnt` first, `mem_we`=1; after `d_rvalid`, fetch granted next IDLE; `stall_fetch` high throughout.
- **Starvation guard:** `d_req` held continuously with `if_req` high, `MaxDataWins`=4 -> 4 data grants, then `if_gnt`, then data resumes.
- **Held command:** `mem_gnt` low for 5 cycles -> `mem_req` and command stable all 5 cycles; no second `gnt`.
- **Timeout** (`MEM_ARB_TIMEOUT_EN`, `TimeoutCycles`=8): load granted, `mem_rvalid` never asserted -> after 8 cycles in WAIT_RSP, `err`=1 and `d_rvalid`=1 with `d_rdata`=0 for one cycle, then IDLE.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: bus bundle for the shared instruction/data memory arbiter.
// Groups the fetch port, the load/store port and the single memory port.
// The slave modport is the arbiter's view; master is the pipeline plus memory side.
interface imem_dmem_arbiter_if #(
    parameter int DPW = 32,
    parameter int ADW = 32
);
    // fetch path
    logic           if_req;
    logic [ADW-1:0] if_addr;
    logic           if_gnt;
    logic           if_rvalid;
    logic [DPW-1:0] if_rdata;
    logic           stall_fetch;

    // load/store path
    logic           d_req;
    logic           d_we;
    logic [3:0]     d_be;
    logic [ADW-1:0] d_addr;
    logic [DPW-1:0] d_wdata;
    logic           d_gnt;
    logic           d_rvalid;
    logic [DPW-1:0] d_rdata;

    // shared memory port
    logic           mem_req;
    logic           mem_we;
    logic [3:0]     mem_be;
    logic [ADW-1:0] mem_addr;
    logic [DPW-1:0] mem_wdata;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [DPW-1:0] mem_rdata;

    // timeout pulse
    logic           err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, stall_fetch,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, stall_fetch,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  err
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory port between instruction fetch and the
// load/store stage. One transaction in flight at a time (IDLE -> ISSUE -> WAIT_RSP).
// Data wins arbitration by default; after MaxDataWins consecutive data wins with
// fetch pending, fetch is forced through.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a WAIT_RSP watchdog that
// completes the transaction with zero data and pulses err.
module imem_dmem_arbiter #(
    parameter int DPW           = 32,
    parameter int ADW           = 32,
    parameter int MaxDataWins   = 4,
    parameter int TimeoutCycles = 64
) (
    input logic                clk,
    input logic                rst,
    imem_dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    localparam logic [3:0] MAX_WINS = 4'(MaxDataWins);

    if (MaxDataWins < 1 || MaxDataWins > 15) begin : g_bad_max_wins
        $error("MaxDataWins must be in 1..15");
    end
    if (TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_bad_timeout
        $error("TimeoutCycles must be in 2..255");
    end

    state_t         state_q;
    state_t         state_d;
    owner_t         owner_q;
    logic [3:0]     data_wins_q;

    logic [ADW-1:0] cmd_addr_q;
    logic           cmd_we_q;
    logic [3:0]     cmd_be_q;
    logic [DPW-1:0] cmd_wdata_q;

    logic           fetch_pick;
    logic           grant_fetch;
    logic           grant_data;
    logic           rsp_fire;
    logic           tmo_hit;
    logic [DPW-1:0] rsp_data;

    // Fetch only beats a concurrent data request once data has used up its win budget.
    assign fetch_pick = bus.if_req && (!bus.d_req || (data_wins_q == MAX_WINS));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TimeoutCycles - 1);

    logic [7:0] tmo_cnt_q;

    // Watchdog: counts cycles spent in WAIT_RSP, restarted on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ISSUE && bus.mem_gnt) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT_RSP) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    // A real response in the final cycle takes priority over the timeout.
    assign tmo_hit = !rst && (state_q == WAIT_RSP) && (tmo_cnt_q == TMO_LAST) && !bus.mem_rvalid;
    assign bus.err = tmo_hit;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Next-state and handshake decode; nothing is granted or returned while in reset.
    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        rsp_fire    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        if (fetch_pick) begin
                            grant_fetch = 1'b1;
                        end else begin
                            grant_data = 1'b1;
                        end
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) begin
                        state_d = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (bus.mem_rvalid || tmo_hit) begin
                        rsp_fire = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state: FSM, transaction owner and the starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DATA;
            data_wins_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_fetch) begin
                owner_q <= OWN_FETCH;
            end else if (grant_data) begin
                owner_q <= OWN_DATA;
            end
            if (!bus.if_req || grant_fetch) begin
                data_wins_q <= '0;
            end else if (grant_data && data_wins_q != MAX_WINS) begin
                data_wins_q <= data_wins_q + 4'd1;
            end
        end
    end

    // Command capture at grant; held untouched until the next grant so ISSUE stays stable.
    always_ff @(posedge clk) begin
        if (grant_fetch) begin
            cmd_addr_q  <= bus.if_addr;
            cmd_we_q    <= 1'b0;
            cmd_be_q    <= 4'hF;
            cmd_wdata_q <= '0;
        end else if (grant_data) begin
            cmd_addr_q  <= bus.d_addr;
            cmd_we_q    <= bus.d_we;
            cmd_be_q    <= bus.d_be;
            cmd_wdata_q <= bus.d_wdata;
        end
    end

    // Timeout completions return zero, which falls out because mem_rvalid is low then.
    assign rsp_data = bus.mem_rvalid ? bus.mem_rdata : '0;

    assign bus.if_gnt      = grant_fetch;
    assign bus.d_gnt       = grant_data;
    assign bus.if_rvalid   = rsp_fire && (owner_q == OWN_FETCH);
    assign bus.d_rvalid    = rsp_fire && (owner_q == OWN_DATA);
    assign bus.if_rdata    = bus.if_rvalid ? rsp_data : '0;
    assign bus.d_rdata     = bus.d_rvalid ? rsp_data : '0;
    assign bus.stall_fetch = bus.if_req && !bus.if_rvalid;

    // Memory command is only driven while issuing; otherwise the port reads as zero.
    assign bus.mem_req   = !rst && (state_q == ISSUE);
    assign bus.mem_we    = bus.mem_req && cmd_we_q;
    assign bus.mem_be    = bus.mem_req ? cmd_be_q : 4'h0;
    assign bus.mem_addr  = bus.mem_req ? cmd_addr_q : '0;
    assign bus.mem_wdata = bus.mem_req ? cmd_wdata_q : '0;

endmodule
